// File: rtl/workout_pkg.sv
// Shared encodings and widths for the workout session controller.
package workout_pkg;

  localparam int HR_W   = 8;
  localparam int STEP_W = 3;
  localparam int SECS_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_PAUSED = 3'd2,
    ST_ALARM  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    HR_SAFE  = 2'b00,
    HR_WARN  = 2'b01,
    HR_EMERG = 2'b10
  } hr_class_e;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick generator: counts 0..TICK_DIV-1 and pulses sec_tick for
// the cycle after the last count. restart zeroes the count and drops the pulse.
module sec_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic sec_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == LAST);
      cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign sec_tick = tick_q;

endmodule

// File: rtl/workout_session_ctrl.sv
// Workout session sequencer: single-entry sample buffer, per-second datapath
// strobe and session FSM. Auto-pause is built only with WORKOUT_AUTO_PAUSE_EN.
//   state  | meaning
//   IDLE   | no session yet, samples dropped
//   ACTIVE | session running, samples buffered and forwarded each tick
//   PAUSED | session held, seconds kept
//   ALARM  | emergency heart rate seen, waiting for acknowledge
//   DONE   | session ended, seconds held
module workout_session_ctrl
  import workout_pkg::*;
#(
  parameter int TICK_DIV         = 50000000,
  parameter int EMERG_SECS       = 3,
  parameter int IDLE_TIMEOUT     = 10,
  parameter int MAX_SESSION_SECS = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_btn,
  input  logic              pause_btn,
  input  logic              stop_btn,
  input  logic              smp_valid,
  output logic              smp_ready,
  input  logic [HR_W-1:0]   smp_hr,
  input  logic [STEP_W-1:0] smp_steps,
  input  logic [1:0]        hr_class,
  output logic              calc_valid,
  output logic [HR_W-1:0]   calc_hr,
  output logic [STEP_W-1:0] calc_steps,
  output logic              calc_clear,
  output logic [2:0]        state,
  output logic [SECS_W-1:0] session_secs,
  output logic              alarm,
  output logic              sec_tick
);

  localparam logic [3:0]        EMERG_LIM = 4'(EMERG_SECS);
  localparam logic [7:0]        IDLE_LIM  = 8'(IDLE_TIMEOUT);
  localparam logic [SECS_W-1:0] SECS_MAX  = SECS_W'(MAX_SESSION_SECS);

  state_e              state_q, state_d;
  logic                buf_full_q;
  logic [HR_W-1:0]     buf_hr_q;
  logic [STEP_W-1:0]   buf_steps_q;
  logic                calc_valid_q, calc_clear_q, alarm_q;
  logic [HR_W-1:0]     calc_hr_q;
  logic [STEP_W-1:0]   calc_steps_q;
  logic [SECS_W-1:0]   session_secs_q, secs_inc;
  logic [3:0]          emerg_q, emerg_inc, emerg_upd;

  logic active, tick_act, xfer;
  logic emerg_hit, idle_hit, max_hit;
  logic enter, new_sess, stay, fwd;

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart  (enter),
    .sec_tick (sec_tick)
  );

  assign active    = (state_q == ST_ACTIVE);
  assign tick_act  = active && sec_tick;
  assign smp_ready = !active || !buf_full_q;
  assign xfer      = smp_valid && smp_ready;

  assign secs_inc  = (session_secs_q == '1) ? session_secs_q : session_secs_q + SECS_W'(1);
  assign emerg_inc = (emerg_q == 4'hF) ? emerg_q : emerg_q + 4'd1;
  assign emerg_upd = (hr_class == HR_EMERG) ? emerg_inc : 4'd0;
  assign emerg_hit = calc_valid_q && (emerg_upd >= EMERG_LIM);
  assign max_hit   = tick_act && (secs_inc >= SECS_MAX);

`ifdef WORKOUT_AUTO_PAUSE_EN
  logic [7:0] idle_q, idle_inc;

  assign idle_inc = idle_q + 8'd1;
  assign idle_hit = tick_act && !buf_full_q && (idle_inc >= IDLE_LIM);

  always_ff @(posedge clk) begin
    if (!rst)          idle_q <= '0;
    else if (enter)    idle_q <= '0;
    else if (tick_act) idle_q <= buf_full_q ? 8'd0 : idle_inc;
  end
`else
  logic unused_idle_lim;
  assign unused_idle_lim = ^IDLE_LIM;
  assign idle_hit        = 1'b0;
`endif

  // Stop outranks everything, then pause, then the automatic exits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_btn) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (stop_btn)       state_d = ST_DONE;
        else if (pause_btn) state_d = ST_PAUSED;
        else if (emerg_hit) state_d = ST_ALARM;
        else if (idle_hit)  state_d = ST_PAUSED;
        else if (max_hit)   state_d = ST_DONE;
      end
      ST_PAUSED, ST_ALARM: begin
        if (stop_btn)       state_d = ST_DONE;
        else if (start_btn) state_d = ST_ACTIVE;
      end
      ST_DONE:   if (start_btn) state_d = ST_ACTIVE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign enter    = !active && (state_d == ST_ACTIVE);
  assign new_sess = enter && (state_q == ST_IDLE || state_q == ST_DONE);
  assign stay     = active && (state_d == ST_ACTIVE);
  assign fwd      = stay && sec_tick && buf_full_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      buf_full_q     <= 1'b0;
      buf_hr_q       <= '0;
      buf_steps_q    <= '0;
      calc_valid_q   <= 1'b0;
      calc_clear_q   <= 1'b0;
      calc_hr_q      <= '0;
      calc_steps_q   <= '0;
      session_secs_q <= '0;
      emerg_q        <= '0;
      alarm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      calc_valid_q <= fwd;
      calc_clear_q <= new_sess;
      alarm_q      <= (state_d == ST_ALARM);
      if (fwd) begin
        calc_hr_q    <= buf_hr_q;
        calc_steps_q <= buf_steps_q;
      end
      // Leaving ACTIVE flushes; a full buffer never accepts, so no overwrite.
      if (!stay || fwd) begin
        buf_full_q <= 1'b0;
      end else if (xfer) begin
        buf_full_q  <= 1'b1;
        buf_hr_q    <= smp_hr;
        buf_steps_q <= smp_steps;
      end
      if (new_sess)      session_secs_q <= '0;
      else if (tick_act) session_secs_q <= secs_inc;
      if (new_sess || (enter && state_q == ST_ALARM)) emerg_q <= '0;
      else if (calc_valid_q)                          emerg_q <= emerg_upd;
    end
  end

  assign state        = state_q;
  assign calc_valid   = calc_valid_q;
  assign calc_clear   = calc_clear_q;
  assign calc_hr      = calc_hr_q;
  assign calc_steps   = calc_steps_q;
  assign session_secs = session_secs_q;
  assign alarm        = alarm_q;

endmodule
